// File: rtl/rot_knob_pkg.sv
// Shared constants for the rotary-encoder controller: FSM encoding, acceleration
// constants and the channel-index width helper.
package rot_knob_pkg;

    localparam logic [1:0] ST_NAV    = 2'd0;
    localparam logic [1:0] ST_EDIT   = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    localparam int ACCEL_GAP   = 1 << 20;
    localparam int ACCEL_STEP  = 4;
    // One extra bit so the counter can sit at or above ACCEL_GAP.
    localparam int ACCEL_CNT_W = $clog2(ACCEL_GAP) + 1;

    function automatic int ch_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rot_knob_ctrl_btn_debounce.sv
// Push-button conditioning: 2-FF synchronizer, stability counter and a
// one-cycle press pulse on the debounced rising edge.
module btn_debounce
    import rot_knob_pkg::*;
#(
    parameter int DB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press,
    output logic level
);

    localparam int CNT_W = $clog2(DB_CYCLES + 1);

    logic             sync_a;
    logic             sync_b;
    logic [CNT_W-1:0] cnt;

    // cnt counts consecutive synchronized samples that disagree with level;
    // the DB_CYCLES-th such sample flips level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            level  <= 1'b0;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync_a <= btn;
            sync_b <= sync_a;
            press  <= 1'b0;
            if (sync_b == level) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DB_CYCLES - 1)) begin
                level <= sync_b;
                cnt   <= '0;
                press <= sync_b;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rot_knob_ctrl.sv
// Rotary input controller: NAV selects a channel, EDIT adjusts a shadow value,
// COMMIT hands the value downstream. Optional step acceleration.
module rot_knob_ctrl
    import rot_knob_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int VAL_W     = 8,
    parameter int DB_CYCLES = 16,
    parameter int INIT_VAL  = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      event_i,
    input  logic                      right_i,
    input  logic                      btn_i,
    output logic [ch_w(N_CH)-1:0]     sel_o,
    output logic                      edit_o,
    output logic [VAL_W-1:0]          edit_val_o,
    output logic [N_CH*VAL_W-1:0]     vals_o,
    output logic                      upd_valid_o,
    output logic [ch_w(N_CH)-1:0]     upd_ch_o,
    output logic [VAL_W-1:0]          upd_val_o,
    input  logic                      upd_ready_i
);

    localparam int                CH_W    = ch_w(N_CH);
    localparam int                SUM_W   = VAL_W + 1;
    localparam logic [CH_W-1:0]   SEL_MAX = CH_W'(N_CH - 1);
    localparam logic [VAL_W-1:0]  INIT_V  = VAL_W'(INIT_VAL);

    logic [1:0]       state;
    logic [CH_W-1:0]  sel;
    logic [VAL_W-1:0] edit_val;
    logic [VAL_W-1:0] vals [N_CH];
    logic             upd_valid;
    logic [CH_W-1:0]  upd_ch;
    logic [VAL_W-1:0] upd_val;

    logic             press;
    logic             btn_level;
    logic [SUM_W-1:0] step;
    logic [SUM_W-1:0] sum;
    logic [VAL_W-1:0] up_val;
    logic [VAL_W-1:0] dn_val;
    logic [CH_W-1:0]  sel_next;

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_btn_debounce (
        .clk   (clk),
        .rst   (rst),
        .btn   (btn_i),
        .press (press),
        .level (btn_level)
    );

`ifdef ROT_KNOB_ACCEL_EN
    logic [ACCEL_CNT_W-1:0] gap_cnt;
    logic                   ev_taken;

    // An event is accepted only where the FSM acts on it (press wins).
    assign ev_taken = event_i && !press && (state == ST_NAV || state == ST_EDIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            gap_cnt <= '0;
        end else if (ev_taken) begin
            gap_cnt <= '0;
        end else if (gap_cnt != '1) begin
            gap_cnt <= gap_cnt + 1'b1;
        end
    end

    assign step = (gap_cnt < ACCEL_CNT_W'(ACCEL_GAP)) ? SUM_W'(ACCEL_STEP) : SUM_W'(1);
`else
    assign step = SUM_W'(1);
`endif

    // Saturating shadow-value arithmetic; no wrap in either direction.
    always_comb begin
        sum    = {1'b0, edit_val} + step;
        up_val = sum[VAL_W] ? '1 : sum[VAL_W-1:0];
        dn_val = ({1'b0, edit_val} < step) ? '0 : (edit_val - step[VAL_W-1:0]);
    end

    always_comb begin
        sel_next = sel;
        if (right_i) begin
            sel_next = (sel == SEL_MAX) ? '0 : sel + 1'b1;
        end else begin
            sel_next = (sel == '0) ? SEL_MAX : sel - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_NAV;
            sel       <= '0;
            edit_val  <= INIT_V;
            upd_valid <= 1'b0;
            upd_ch    <= '0;
            upd_val   <= '0;
            for (int k = 0; k < N_CH; k++) begin
                vals[k] <= INIT_V;
            end
        end else begin
            case (state)
                ST_NAV: begin
                    if (press) begin
                        edit_val <= vals[sel];
                        state    <= ST_EDIT;
                    end else if (event_i) begin
                        sel <= sel_next;
                    end
                end
                ST_EDIT: begin
                    if (press) begin
                        vals[sel] <= edit_val;
                        upd_ch    <= sel;
                        upd_val   <= edit_val;
                        upd_valid <= 1'b1;
                        state     <= ST_COMMIT;
                    end else if (event_i) begin
                        edit_val <= right_i ? up_val : dn_val;
                    end
                end
                ST_COMMIT: begin
                    if (upd_ready_i) begin
                        upd_valid <= 1'b0;
                        state     <= ST_NAV;
                    end
                end
                default: begin
                    state <= ST_NAV;
                end
            endcase
        end
    end

    assign sel_o       = sel;
    assign edit_o      = (state == ST_EDIT);
    assign edit_val_o  = edit_val;
    assign upd_valid_o = upd_valid;
    assign upd_ch_o    = upd_ch;
    assign upd_val_o   = upd_val;

    for (genvar g = 0; g < N_CH; g++) begin : g_pack
        assign vals_o[g*VAL_W +: VAL_W] = vals[g];
    end

endmodule

// File: tb/tb_rot_knob_ctrl.sv
// Self-checking bench for rot_knob_ctrl: transaction-level reference model,
// update scoreboard with an expected queue, directed plus random stimulus.
module tb_rot_knob_ctrl;

    localparam int N_CH      = 4;
    localparam int VAL_W     = 8;
    localparam int DB_CYCLES = 16;
    localparam int INIT_VAL  = 0;
    localparam int MAXV      = (1 << VAL_W) - 1;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  event_i = 1'b0;
    logic                  right_i = 1'b0;
    logic                  btn_i = 1'b0;
    logic                  upd_ready_i = 1'b0;
    logic [1:0]            sel_o;
    logic                  edit_o;
    logic [VAL_W-1:0]      edit_val_o;
    logic [N_CH*VAL_W-1:0] vals_o;
    logic                  upd_valid_o;
    logic [1:0]            upd_ch_o;
    logic [VAL_W-1:0]      upd_val_o;

    rot_knob_ctrl #(
        .N_CH      (N_CH),
        .VAL_W     (VAL_W),
        .DB_CYCLES (DB_CYCLES),
        .INIT_VAL  (INIT_VAL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .event_i     (event_i),
        .right_i     (right_i),
        .btn_i       (btn_i),
        .sel_o       (sel_o),
        .edit_o      (edit_o),
        .edit_val_o  (edit_val_o),
        .vals_o      (vals_o),
        .upd_valid_o (upd_valid_o),
        .upd_ch_o    (upd_ch_o),
        .upd_val_o   (upd_val_o),
        .upd_ready_i (upd_ready_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Expected updates as {channel, value}.
    logic [VAL_W+1:0] exp_q[$];
    logic [VAL_W+1:0] exp_e;

    // Reference model: mode 0 = selecting, 1 = editing, 2 = waiting on handshake.
    int sel_m;
    int edit_m;
    int mode_m;
    int vals_m[N_CH];

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_sel"}, int'(sel_o), sel_m);
        check({tag, "_edit"}, int'(edit_o), (mode_m == 1) ? 1 : 0);
        check({tag, "_edit_val"}, int'(edit_val_o), edit_m);
        check({tag, "_upd_valid"}, int'(upd_valid_o), (mode_m == 2) ? 1 : 0);
        for (int k = 0; k < N_CH; k++) begin
            check($sformatf("%s_val%0d", tag, k), int'(vals_o[k*VAL_W +: VAL_W]), vals_m[k]);
        end
    endtask

    task automatic model_reset();
        sel_m  = 0;
        edit_m = INIT_VAL;
        mode_m = 0;
        for (int k = 0; k < N_CH; k++) vals_m[k] = INIT_VAL;
        exp_q.delete();
    endtask

    task automatic model_ev(input logic dir);
        if (mode_m == 0) begin
            sel_m = (sel_m + (dir ? 1 : N_CH - 1)) % N_CH;
        end else if (mode_m == 1) begin
            if (dir) edit_m = (edit_m + 1 > MAXV) ? MAXV : edit_m + 1;
            else     edit_m = (edit_m == 0) ? 0 : edit_m - 1;
        end
    endtask

    task automatic model_press();
        logic [1:0]       ch;
        logic [VAL_W-1:0] v;
        if (mode_m == 0) begin
            edit_m = vals_m[sel_m];
            mode_m = 1;
        end else if (mode_m == 1) begin
            vals_m[sel_m] = edit_m;
            ch = 2'(sel_m);
            v  = VAL_W'(edit_m);
            exp_q.push_back({ch, v});
            mode_m = 2;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ev(input logic dir, input string tag);
        event_i = 1'b1;
        right_i = dir;
        tick();
        event_i = 1'b0;
        right_i = 1'($urandom_range(0, 1));
        model_ev(dir);
        check_all(tag);
    endtask

    task automatic press_btn(input string tag);
        btn_i = 1'b1;
        repeat (DB_CYCLES + 4) tick();
        btn_i = 1'b0;
        repeat (DB_CYCLES + 4) tick();
        model_press();
        check_all(tag);
    endtask

    task automatic handshake(input int n_low, input string tag);
        int cnt;
        cnt = 0;
        for (int i = 0; i < n_low; i++) begin
            if (upd_valid_o) cnt++;
            tick();
        end
        upd_ready_i = 1'b1;
        if (upd_valid_o) cnt++;
        tick();
        upd_ready_i = 1'b0;
        check({tag, "_valid_cycles"}, cnt, n_low + 1);
        mode_m = 0;
        check_all(tag);
    endtask

    // Scoreboard monitor: every accepted update must match the queue head.
    always @(negedge clk) begin
        if (!rst && upd_valid_o && upd_ready_i) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL upd_unexpected ch %0d val %0d expected none", upd_ch_o, upd_val_o);
            end else begin
                exp_e = exp_q.pop_front();
                check("upd_ch", int'(upd_ch_o), int'(exp_e[VAL_W+1:VAL_W]));
                check("upd_val", int'(upd_val_o), int'(exp_e[VAL_W-1:0]));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int found;
        int r;
        model_reset();
        repeat (3) tick();
        check_all("reset");
        check("reset_upd_ch", int'(upd_ch_o), 0);
        check("reset_upd_val", int'(upd_val_o), 0);
        rst = 1'b0;
        tick();

        repeat (5) ev(1'b1, "nav_right");
        ev(1'b0, "nav_left");
        ev(1'b0, "nav_wrap_down");
        ev(1'b0, "nav_to2");

        press_btn("enter_ch2");
        repeat (3) ev(1'b1, "edit_right");
        ev(1'b0, "edit_left");
        press_btn("commit_ch2");
        handshake(4, "hs_ch2");

        ev(1'b0, "nav_to1");
        press_btn("enter_ch1");
        repeat (254) ev(1'b1, "edit_climb");
        repeat (3) ev(1'b1, "sat_high");
        repeat (254) ev(1'b0, "edit_fall");
        repeat (3) ev(1'b0, "sat_low");
        repeat (5) ev(1'b1, "edit_to5");
        press_btn("commit_ch1");
        handshake(0, "hs_ch1");

        upd_ready_i = 1'b1;
        ev(1'b1, "ready_early");
        upd_ready_i = 1'b0;

        btn_i = 1'b1;
        repeat (DB_CYCLES - 1) tick();
        btn_i = 1'b0;
        repeat (2 * DB_CYCLES) tick();
        check_all("glitch");
        btn_i = 1'b1;
        repeat (DB_CYCLES + 2) tick();
        btn_i = 1'b0;
        repeat (2 * DB_CYCLES) tick();
        model_press();
        check_all("long_press");
        ev(1'b1, "edit_after_long");
        press_btn("commit_long");
        handshake(2, "hs_long");

        press_btn("enter_pre_rst");
        repeat (2) ev(1'b1, "edit_pre_rst");
        press_btn("commit_pre_rst");
        rst = 1'b1;
        tick();
        model_reset();
        check_all("rst_in_commit");
        rst = 1'b0;
        tick();
        check_all("after_rst");

        btn_i = 1'b1;
        n = 0;
        found = 0;
        while (found == 0 && n < 4 * DB_CYCLES) begin
            event_i = 1'b1;
            right_i = 1'b1;
            tick();
            n++;
            if (edit_o) found = 1;
        end
        event_i = 1'b0;
        check("press_seen", found, 1);
        repeat (n - 1) model_ev(1'b1);
        repeat (DB_CYCLES + 4) tick();
        btn_i = 1'b0;
        repeat (DB_CYCLES + 4) tick();
        model_press();
        check_all("press_wins");
        press_btn("commit_press_wins");
        handshake(1, "hs_press_wins");

        for (int it = 0; it < 60; it++) begin
            r = $urandom_range(0, 9);
            if (r < 8) begin
                repeat ($urandom_range(1, 4)) ev(1'($urandom_range(0, 1)), "rand_ev");
            end else begin
                press_btn("rand_press");
            end
            if (mode_m == 2) handshake($urandom_range(0, 3), "rand_hs");
        end

        tick();
        check("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
